// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the accumulator CPU control path: opcodes, instruction
// field positions, sequencer states and instruction classification.
package cpuPkg;

  localparam logic [3:0] OP_SETC      = 4'h0;
  localparam logic [3:0] OP_INPUT     = 4'h1;
  localparam logic [3:0] OP_COPY      = 4'h2;
  localparam logic [3:0] OP_ADD       = 4'h4;
  localparam logic [3:0] OP_NEG       = 4'h5;
  localparam logic [3:0] OP_CGT       = 4'h6;
  localparam logic [3:0] OP_CJMP      = 4'hC;
  localparam logic [3:0] OP_ILLEGAL_D = 4'hD;
  localparam logic [3:0] OP_HALT      = 4'hE;
  localparam logic [3:0] OP_ILLEGAL_F = 4'hF;

  localparam int FIELD_W    = 4;
  localparam int OPCODE_LSB = 12;
  localparam int DEST_LSB   = 8;
  localparam int SRC1_LSB   = 4;
  localparam int SRC2_LSB   = 0;
  localparam int IMM8_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_HALTED,
    ST_FAULT
  } state_e;

  typedef enum logic [2:0] {
    CLS_DATAPATH,
    CLS_JUMP,
    CLS_CJMP,
    CLS_HALT,
    CLS_ILLEGAL
  } instr_class_e;

  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[OPCODE_LSB +: FIELD_W];
  endfunction

  function automatic logic [3:0] dest_of(input logic [15:0] instr);
    return instr[DEST_LSB +: FIELD_W];
  endfunction

  // A COPY into r0 is the unconditional jump; every other COPY goes to the datapath.
  function automatic instr_class_e classify(input logic [15:0] instr);
    instr_class_e cls;
    case (opcode_of(instr))
      OP_COPY:                    cls = (dest_of(instr) == 4'h0) ? CLS_JUMP : CLS_DATAPATH;
      OP_CJMP:                    cls = CLS_CJMP;
      OP_HALT:                    cls = CLS_HALT;
      OP_ILLEGAL_D, OP_ILLEGAL_F: cls = CLS_ILLEGAL;
      default:                    cls = CLS_DATAPATH;
    endcase
    return cls;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_sequencer_branch_target.sv
// Next-PC computation: pc + 1 + sign-extended offset (4- or 8-bit), evaluated
// in 10 bits so that negative and past-the-end targets are both detectable.
module branch_target #(
  parameter int PC_LIMIT = 127
) (
  input  logic [7:0] pc_i,
  input  logic [7:0] offset_i,
  input  logic       wide_i,
  output logic [7:0] next_pc_o,
  output logic       out_of_range_o
);

  logic [9:0] offset_ext;
  logic [9:0] target;

  // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
  always_comb begin
    offset_ext     = wide_i ? {{2{offset_i[7]}}, offset_i}
                            : {{6{offset_i[3]}}, offset_i[3:0]};
    target         = {2'b00, pc_i} + 10'd1 + offset_ext;
    out_of_range_o = target[9] || (target[8:0] > 9'(PC_LIMIT));
    next_pc_o      = target[7:0];
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter owner for the accumulator CPU: fetches, resolves jumps/HALT
// locally and hands all other instructions to the datapath over valid/ready.
module fetch_sequencer
  import cpuPkg::*;
#(
  parameter int PC_LIMIT = 127
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  programSelect,
  input  logic [15:0] instruction,
  input  logic [7:0]  condValue,
  input  logic        execReady,
  output logic [7:0]  address,
  output logic [7:0]  programSelectLatched,
  output logic        execValid,
  output logic [15:0] execInstr,
  output logic        running,
  output logic        halted,
  output logic        fault,
  output logic [15:0] retired
);

  state_e       state_q;
  logic [7:0]   address_q;
  logic [7:0]   psel_q;
  logic [15:0]  instr_q;
  logic         exec_valid_q;
  logic [15:0]  exec_instr_q;
  logic         running_q;
  logic         halted_q;
  logic         fault_q;
  logic [15:0]  retired_q;

  instr_class_e exec_class;
  logic [7:0]   bt_offset;
  logic         bt_wide;
  logic [7:0]   next_pc_d;
  logic         next_pc_oor;
  logic         step_done;

  assign exec_class = classify(instr_q);

  // Sequential advance is a zero offset; a not-taken conditional jump is the same.
  always_comb begin
    bt_offset = 8'h00;
    bt_wide   = 1'b0;
    if (exec_class == CLS_JUMP) begin
      bt_offset = instr_q[IMM8_W-1:0];
      bt_wide   = 1'b1;
    end else if (exec_class == CLS_CJMP && condValue != 8'h00) begin
      bt_offset = {4'h0, instr_q[SRC2_LSB +: FIELD_W]};
    end
  end

  branch_target #(
    .PC_LIMIT (PC_LIMIT)
  ) u_branch_target (
    .pc_i           (address_q),
    .offset_i       (bt_offset),
    .wide_i         (bt_wide),
    .next_pc_o      (next_pc_d),
    .out_of_range_o (next_pc_oor)
  );

  assign step_done = (state_q == ST_EXEC) &&
                     ((exec_class == CLS_JUMP) || (exec_class == CLS_CJMP) ||
                      ((exec_class == CLS_DATAPATH) && exec_valid_q && execReady));

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      address_q    <= '0;
      psel_q       <= '0;
      instr_q      <= '0;
      exec_valid_q <= 1'b0;
      exec_instr_q <= '0;
      running_q    <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
      retired_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HALTED, ST_FAULT: begin
          if (start) begin
            address_q <= '0;
            retired_q <= '0;
            psel_q    <= programSelect;
            halted_q  <= 1'b0;
            if (programSelect == 8'h00) begin
              state_q   <= ST_FAULT;
              running_q <= 1'b0;
              fault_q   <= 1'b1;
            end else begin
              state_q   <= ST_FETCH;
              running_q <= 1'b1;
              fault_q   <= 1'b0;
            end
          end
        end

        ST_FETCH: begin
          instr_q <= instruction;
          state_q <= ST_EXEC;
          if (classify(instruction) == CLS_DATAPATH) begin
            exec_valid_q <= 1'b1;
            exec_instr_q <= instruction;
          end
        end

        ST_EXEC: begin
          if (step_done) begin
            exec_valid_q <= 1'b0;
            // An out-of-range next PC leaves address at the faulting instruction.
            if (next_pc_oor) begin
              state_q   <= ST_FAULT;
              running_q <= 1'b0;
              fault_q   <= 1'b1;
            end else begin
              address_q <= next_pc_d;
              retired_q <= sat_inc16(retired_q);
              state_q   <= ST_FETCH;
            end
          end else if (exec_class == CLS_HALT) begin
            retired_q <= sat_inc16(retired_q);
            state_q   <= ST_HALTED;
            running_q <= 1'b0;
            halted_q  <= 1'b1;
          end else if (exec_class == CLS_ILLEGAL) begin
            state_q   <= ST_FAULT;
            running_q <= 1'b0;
            fault_q   <= 1'b1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign address              = address_q;
  assign programSelectLatched = psel_q;
  assign execValid            = exec_valid_q;
  assign execInstr            = exec_instr_q;
  assign running              = running_q;
  assign halted               = halted_q;
  assign fault                = fault_q;
  assign retired              = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: instruction memory and register
// file are modelled here; results are compared with an ISA-level program model.
module tb_fetch_sequencer;

  localparam int OUT_HALT  = 1;
  localparam int OUT_FAULT = 2;
  localparam int OUT_LOOP  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  programSelect;
  logic [15:0] instruction;
  logic [7:0]  condValue;
  logic        execReady;
  logic [7:0]  address;
  logic [7:0]  programSelectLatched;
  logic        execValid;
  logic [15:0] execInstr;
  logic        running;
  logic        halted;
  logic        fault;
  logic [15:0] retired;

  logic [15:0] mem [128];
  logic [7:0]  cond_table [16];

  assign instruction = mem[address[6:0]];
  assign condValue   = cond_table[mem[address[6:0]][7:4]];

  fetch_sequencer #(.PC_LIMIT(127)) dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .programSelect        (programSelect),
    .instruction          (instruction),
    .condValue            (condValue),
    .execReady            (execReady),
    .address              (address),
    .programSelectLatched (programSelectLatched),
    .execValid            (execValid),
    .execInstr            (execInstr),
    .running              (running),
    .halted               (halted),
    .fault                (fault),
    .retired              (retired)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] got_q [$];
  logic [15:0] exp_q [$];

  typedef struct {
    logic [15:0] instr;
    int          pc;
    logic [7:0]  cond;
    int          exp_outcome;
    int          exp_addr;
    int          exp_retired;
    int          exp_issued;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic [15:0] instr, input int pc, input logic [7:0] cond,
                              input int outcome, input int addr, input int ret, input int issued);
    vec_t v;
    v.instr = instr; v.pc = pc; v.cond = cond;
    v.exp_outcome = outcome; v.exp_addr = addr; v.exp_retired = ret; v.exp_issued = issued;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem(input logic [15:0] word);
    for (int i = 0; i < 128; i++) mem[i] = word;
  endtask

  task automatic fill_cond(input logic [7:0] value);
    for (int i = 0; i < 16; i++) cond_table[i] = value;
  endtask

  task automatic start_run(input logic [7:0] ps);
    start = 1'b1;
    programSelect = ps;
    tick();
    start = 1'b0;
  endtask

  // Clocks until HALTED/FAULT or the budget expires, logging every handshake.
  task automatic run_to_end(input int budget, input bit rand_ready, input bit rand_noise,
                            output int cycles, output int excl_err, output bit done);
    int stall;
    stall = 0; cycles = 0; excl_err = 0; done = 1'b0;
    got_q.delete();
    while (cycles < budget && !done) begin
      execReady = rand_ready ? ((stall >= 4) || ($urandom_range(0, 3) != 0)) : 1'b1;
      if (execValid && !execReady) stall++;
      else stall = 0;
      if (rand_noise) begin
        start = ($urandom_range(0, 7) == 0);
        programSelect = 8'($urandom);
      end
      if (execValid && execReady) got_q.push_back(execInstr);
      tick();
      cycles++;
      if ($countones({running, halted, fault}) > 1) excl_err++;
      if (halted || fault) done = 1'b1;
    end
    start = 1'b0;
    execReady = 1'b0;
  endtask

  // Executes the program in mem at instruction granularity.
  function automatic void model_run(output int outcome, output int fin_addr,
                                    output int ret, output int steps);
    int pc, tgt;
    logic [15:0] w;
    pc = 0; ret = 0; steps = 0; outcome = OUT_LOOP; fin_addr = 0;
    exp_q.delete();
    while (steps < 200) begin
      w = mem[pc];
      steps++;
      fin_addr = pc;
      if (w[15:12] == 4'hE) begin
        ret++;
        outcome = OUT_HALT;
        return;
      end
      if (w[15:12] == 4'hD || w[15:12] == 4'hF) begin
        outcome = OUT_FAULT;
        return;
      end
      if (w[15:8] == 8'h20) tgt = pc + 1 + int'($signed(w[7:0]));
      else if (w[15:12] == 4'hC)
        tgt = (cond_table[w[7:4]] != 8'h00) ? pc + 1 + int'($signed(w[3:0])) : pc + 1;
      else begin
        exp_q.push_back(w);
        tgt = pc + 1;
      end
      if (tgt < 0 || tgt > 127) begin
        outcome = OUT_FAULT;
        return;
      end
      pc = tgt;
      ret++;
    end
  endfunction

  task automatic gen_program();
    int r, tmp;
    logic [15:0] w;
    for (int i = 0; i < 128; i++) begin
      r = $urandom_range(0, 99);
      w = 16'($urandom);
      if (r < 60) begin
        w[15:12] = 4'($urandom_range(0, 11));
        if (w[15:12] == 4'h2 && w[11:8] == 4'h0) w[11:8] = 4'h1;
      end else if (r < 70) begin
        w[15:8] = 8'h20;
        if ($urandom_range(0, 4) == 0) begin
          tmp = $urandom_range(100, 128);
          w[7:0] = 8'(-tmp);
        end else begin
          tmp = $urandom_range(0, 12);
          w[7:0] = 8'(tmp - 3);
        end
      end else if (r < 82) w[15:12] = 4'hC;
      else if (r < 90) w = 16'hE000;
      else if (r < 93) w[15:12] = ($urandom_range(0, 1) == 0) ? 4'hD : 4'hF;
      else w[15:12] = 4'h4;
      mem[i] = w;
    end
    for (int i = 0; i < 16; i++)
      cond_table[i] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
  endtask

  initial begin
    int cyc, excl, outcome, fin_addr, ret, steps, bad, tries;
    bit done;
    logic [7:0] ps;

    vecs[0]  = mk(16'h2002,   0, 8'h00, OUT_HALT,    3, 2, 0);
    vecs[1]  = mk(16'h20F0,   3, 8'h00, OUT_FAULT,   3, 1, 0);
    vecs[2]  = mk(16'hC051,   0, 8'h01, OUT_HALT,    2, 2, 0);
    vecs[3]  = mk(16'hC051,   0, 8'h00, OUT_HALT,    1, 2, 0);
    vecs[4]  = mk(16'hF000,   0, 8'h00, OUT_FAULT,   0, 0, 0);
    vecs[5]  = mk(16'hD123,   5, 8'h00, OUT_FAULT,   5, 1, 0);
    vecs[6]  = mk(16'h4F21, 127, 8'h00, OUT_FAULT, 127, 1, 1);
    vecs[7]  = mk(16'h207F,   0, 8'h00, OUT_FAULT,   0, 0, 0);
    vecs[8]  = mk(16'h207E,   0, 8'h00, OUT_HALT,  127, 2, 0);
    vecs[9]  = mk(16'hC0F8,  10, 8'h07, OUT_HALT,    3, 3, 0);
    vecs[10] = mk(16'hC0F8,   3, 8'h07, OUT_FAULT,   3, 1, 0);
    vecs[11] = mk(16'h2A10,   0, 8'h00, OUT_HALT,    1, 2, 1);
    vecs[12] = mk(16'hE000,   0, 8'h00, OUT_HALT,    0, 1, 0);
    vecs[13] = mk(16'h2080, 100, 8'h00, OUT_FAULT, 100, 1, 0);
    vecs[14] = mk(16'hC007, 120, 8'h03, OUT_FAULT, 120, 1, 0);
    vecs[15] = mk(16'hC0F8,  10, 8'h00, OUT_HALT,   11, 3, 0);

    reset = 1'b0; start = 1'b0; execReady = 1'b0; programSelect = 8'h00;
    fill_mem(16'hE000);
    fill_cond(8'h00);
    #1 reset = 1'b1;
    #1;
    check("reset_addr_psel_instr", {address, programSelectLatched, execInstr}, 32'h0);
    check("reset_status_retired", {execValid, running, halted, fault, retired}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Straight-line program with the datapath always ready.
    mem[0] = 16'h0102; mem[1] = 16'h2F10; mem[2] = 16'h0203; mem[3] = 16'h4F21; mem[4] = 16'hE000;
    start_run(8'h01);
    check("A_start_running", running, 1);
    check("A_start_addr", address, 0);
    run_to_end(40, 1'b0, 1'b0, cyc, excl, done);
    check("A_cycles_to_halt", cyc, 10);
    check("A_halted", {halted, fault, running}, 3'b100);
    check("A_valid_pulses", got_q.size(), 4);
    check("A_retired", retired, 5);
    check("A_addr_held", address, 4);

    // Datapath stall: offer must stay stable while execReady is low.
    fill_mem(16'hE000);
    mem[0] = 16'h4F21;
    start_run(8'h02);
    execReady = 1'b0;
    tick();
    for (int k = 0; k < 6; k++) begin
      check($sformatf("B_stall_%0d", k), {execValid, execInstr, address}, {1'b1, 16'h4F21, 8'h00});
      execReady = (k == 5);
      tick();
    end
    execReady = 1'b0;
    check("B_after_handshake", {execValid, address, retired}, {1'b0, 8'h01, 16'h0001});
    run_to_end(20, 1'b0, 1'b0, cyc, excl, done);
    check("B_final", {halted, retired}, {1'b1, 16'h0002});

    // Asynchronous reset while an instruction is being offered.
    fill_mem(16'hE000);
    mem[0] = 16'h4F21;
    start_run(8'h03);
    tick();
    check("D_offer_before_reset", execValid, 1);
    #2 reset = 1'b1;
    #1;
    check("D_reset_addr_psel_instr", {address, programSelectLatched, execInstr}, 32'h0);
    check("D_reset_status_retired", {execValid, running, halted, fault, retired}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    check("D_idle_after_reset", {running, halted, fault}, 3'b000);

    // Zero program selection faults immediately.
    start_run(8'h00);
    check("E_zero_select_fault", {running, halted, fault}, 3'b001);
    check("E_zero_select_addr_psel", {address, programSelectLatched}, 16'h0000);

    // Sequential run off the end of memory.
    fill_mem(16'h1000);
    start_run(8'h07);
    run_to_end(600, 1'b0, 1'b0, cyc, excl, done);
    check("C_end_fault", {running, halted, fault}, 3'b001);
    check("C_end_addr", address, 127);
    check("C_end_retired", retired, 127);
    check("C_end_issued", got_q.size(), 128);

    // Single-instruction table: mem[0] jumps to the instruction under test, HALT elsewhere.
    for (int v = 0; v < 16; v++) begin
      fill_mem(16'hE000);
      fill_cond(vecs[v].cond);
      if (vecs[v].pc != 0) mem[0] = {8'h20, 8'(vecs[v].pc - 1)};
      mem[vecs[v].pc] = vecs[v].instr;
      start_run(8'h5A);
      run_to_end(80, 1'b1, 1'b0, cyc, excl, done);
      check($sformatf("T%0d_outcome", v), {halted, fault},
            (vecs[v].exp_outcome == OUT_HALT) ? 2'b10 : 2'b01);
      check($sformatf("T%0d_addr", v), address, vecs[v].exp_addr);
      check($sformatf("T%0d_retired", v), retired, vecs[v].exp_retired);
      check($sformatf("T%0d_issued", v), got_q.size(), vecs[v].exp_issued);
    end

    // Random programs against the instruction-level model.
    for (int r = 0; r < 12; r++) begin
      tries = 0;
      do begin
        gen_program();
        model_run(outcome, fin_addr, ret, steps);
        tries++;
        if (tries > 50) begin
          mem[0] = 16'hE000;
          model_run(outcome, fin_addr, ret, steps);
        end
      end while (outcome == OUT_LOOP || steps > 150);
      ps = 8'($urandom_range(1, 255));
      start_run(ps);
      check($sformatf("R%0d_start", r), {running, address, programSelectLatched}, {1'b1, 8'h00, ps});
      run_to_end(steps * 8 + 10, 1'b1, 1'b1, cyc, excl, done);
      check($sformatf("R%0d_done", r), done, 1);
      check($sformatf("R%0d_outcome", r), {halted, fault}, (outcome == OUT_HALT) ? 2'b10 : 2'b01);
      check($sformatf("R%0d_addr", r), address, fin_addr);
      check($sformatf("R%0d_retired", r), retired, ret);
      check($sformatf("R%0d_issued_count", r), got_q.size(), exp_q.size());
      bad = 0;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
        if (got_q[i] !== exp_q[i]) bad++;
      check($sformatf("R%0d_issued_seq", r), bad, 0);
      check($sformatf("R%0d_status_exclusive", r), excl, 0);
      check($sformatf("R%0d_psel_held", r), programSelectLatched, ps);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
